// File: rtl/barcode_entry_buffer.sv
// barcode_entry_buffer: N-digit keypad entry buffer with backspace, clear, commit and idle timeout
module barcode_entry_buffer #(
  parameter  int NUM_DIGITS     = 4,
  parameter  int DIGIT_W        = 4,
  parameter  int MAX_DIGIT      = 9,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int CNT_W          = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          DIGIT_EN,
  input  logic [DIGIT_W-1:0]            DIGIT_IN,
  input  logic                          BACKSPACE_EN,
  input  logic                          CLEAR_EN,
  input  logic                          COMMIT_EN,
  output logic [NUM_DIGITS*DIGIT_W-1:0] DIGITS_OUT,
  output logic [CNT_W-1:0]              DIGIT_COUNT,
  output logic                          COMPLETE,
  output logic                          COMMIT_VALID,
  output logic [NUM_DIGITS*DIGIT_W-1:0] COMMIT_CODE,
  output logic                          ERROR,
  output logic                          TIMEOUT,
  output logic [1:0]                    STATE_OUT
);
  localparam int DW = NUM_DIGITS * DIGIT_W;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);
  localparam logic [DIGIT_W:0] MAX_D = (DIGIT_W + 1)'(MAX_DIGIT);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ENTRY = 2'b01, S_FULL = 2'b10} state_t;
  state_t state_q, state_n;
  logic [DW-1:0] digits_q, digits_n, code_q, code_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [TW-1:0] idle_q, idle_n;
  logic cv_q, cv_n, err_q, err_n, to_q, to_n, req, fire;
  // Serve the single highest-priority request, or the idle timeout when nothing is requested
  always_comb begin
    digits_n = digits_q;
    count_n = count_q;
    code_n = code_q;
    cv_n = 1'b0;
    err_n = 1'b0;
    to_n = 1'b0;
    req = CLEAR_EN | COMMIT_EN | BACKSPACE_EN | DIGIT_EN;
    fire = (TIMEOUT_CYCLES > 0) && !req && count_q != '0 && idle_q == TLIM;
    idle_n = (req || count_q == '0 || fire || TIMEOUT_CYCLES == 0) ? '0 : idle_q + 1'b1;
    if (CLEAR_EN || fire) begin
      digits_n = '0;
      count_n = '0;
      to_n = fire;
    end else if (COMMIT_EN) begin
      if (count_q == FULL_CNT) begin
        code_n = digits_q;
        cv_n = 1'b1;
        digits_n = '0;
        count_n = '0;
      end else err_n = 1'b1;
    end else if (BACKSPACE_EN) begin
      if (count_q != '0) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          if (CNT_W'(k + 1) == count_q) digits_n[k*DIGIT_W +: DIGIT_W] = '0;
        count_n = count_q - 1'b1;
      end else err_n = 1'b1;
    end else if (DIGIT_EN) begin
      if (count_q == FULL_CNT || {1'b0, DIGIT_IN} > MAX_D) err_n = 1'b1;
      else begin
        for (int k = 0; k < NUM_DIGITS; k++)
          if (CNT_W'(k) == count_q) digits_n[k*DIGIT_W +: DIGIT_W] = DIGIT_IN;
        count_n = count_q + 1'b1;
      end
    end
  end
  // Mode follows the digit count that will be held after this edge
  always_comb state_n = count_n == '0 ? S_IDLE : count_n == FULL_CNT ? S_FULL : S_ENTRY;
  // All state and pulse outputs are registered; reset also drops any pending commit pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      digits_q <= '0;
      count_q <= '0;
      code_q <= '0;
      idle_q <= '0;
      cv_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_n;
      digits_q <= digits_n;
      count_q <= count_n;
      code_q <= code_n;
      idle_q <= idle_n;
      cv_q <= cv_n;
      err_q <= err_n;
      to_q <= to_n;
    end
  end
  // Present registered state to the lookup and display logic
  always_comb begin
    STATE_OUT = state_q;
    COMPLETE = state_q == S_FULL;
    DIGITS_OUT = digits_q;
    DIGIT_COUNT = count_q;
    COMMIT_CODE = code_q;
    COMMIT_VALID = cv_q;
    ERROR = err_q;
    TIMEOUT = to_q;
  end
endmodule

// File: doc/barcode_entry_buffer.md
# barcode_entry_buffer

Parametrised digit-entry buffer for the sale terminal. Collects decoded keypad digits into an N-digit barcode with backspace, clear, commit and idle timeout, and presents the packed code to the product lookup and HEX display logic. It sits between the state machine (which issues digit and command pulses) and the hover/basket logic (which consume the committed code). It generalises the fixed 4-digit barcode entry to any length and adds editing, validation and a commit handshake.

## Interface
Parameters:
- NUM_DIGITS, 4, barcode length in digits (≥1)
- DIGIT_W, 4, bits per digit
- MAX_DIGIT, 9, largest legal digit value
- TIMEOUT_CYCLES, 0, idle cycles before auto-clear; 0 disables timeout
- CNT_W (localparam), $clog2(NUM_DIGITS+1), width of the digit count

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- DIGIT_EN  in  1  one-cycle pulse: append DIGIT_IN
- DIGIT_IN  in  DIGIT_W  digit value, sampled when DIGIT_EN=1
- BACKSPACE_EN  in  1  one-cycle pulse: remove last digit
- CLEAR_EN  in  1  one-cycle pulse: discard all digits
- COMMIT_EN  in  1  one-cycle pulse: request commit of full code
- DIGITS_OUT  out  NUM_DIGITS*DIGIT_W  live buffer; slot k (first-entered = slot 0) at bits [k*DIGIT_W +: DIGIT_W]; empty slots are 0
- DIGIT_COUNT  out  CNT_W  number of digits held, 0..NUM_DIGITS
- COMPLETE  out  1  high while DIGIT_COUNT==NUM_DIGITS
- COMMIT_VALID  out  1  one-cycle pulse: COMMIT_CODE newly valid
- COMMIT_CODE  out  NUM_DIGITS*DIGIT_W  last committed code, held until next commit or RESET
- ERROR  out  1  one-cycle pulse on a rejected request
- TIMEOUT  out  1  one-cycle pulse on idle auto-clear
- STATE_OUT  out  2  00 IDLE, 01 ENTRY, 10 FULL

## Operation
- States are derived from the count: IDLE (count 0), ENTRY (0<count<N), FULL (count N).
- Each cycle at most one request is served. Priority: RESET > CLEAR_EN > COMMIT_EN > BACKSPACE_EN > DIGIT_EN. Lower-priority requests asserted in the same cycle are dropped silently, with no ERROR.
- DIGIT_EN:
  - In IDLE or ENTRY with DIGIT_IN ≤ MAX_DIGIT: write DIGIT_IN to slot count, then count+1.
  - With DIGIT_IN > MAX_DIGIT: ERROR, buffer unchanged.
  - In FULL: ERROR, buffer unchanged. There is no wrap and no overwrite.
- BACKSPACE_EN:
  - count>0: zero slot count-1, then count-1.
  - In IDLE: ERROR.
- CLEAR_EN: zero all slots, count 0. Never raises ERROR, including in IDLE.
- COMMIT_EN:
  - In FULL: copy DIGITS_OUT to COMMIT_CODE, pulse COMMIT_VALID, clear buffer to IDLE.
  - Otherwise: ERROR, nothing changes.
- Timeout (only when TIMEOUT_CYCLES>0):
  - An idle counter resets on any served request and whenever count==0.
  - Otherwise it increments each cycle. On reaching TIMEOUT_CYCLES the block performs a clear and pulses TIMEOUT.
  - Any request in the same cycle takes precedence, and the counter restarts.
- RESET mid-entry or mid-commit: all state is zeroed. Any pending COMMIT_VALID is suppressed.

## Timing
- All outputs are registered. A request sampled at edge t is reflected in DIGITS_OUT, DIGIT_COUNT, STATE_OUT and the pulse outputs after edge t, i.e. one cycle of latency.
- COMMIT_VALID and COMMIT_CODE update on the same edge. COMMIT_CODE is stable from then on until the next commit.
- ERROR, TIMEOUT and COMMIT_VALID are each exactly one cycle wide. Back-to-back requests on consecutive cycles are all served.
- Reset values: DIGITS_OUT 0, DIGIT_COUNT 0, COMPLETE 0, COMMIT_VALID 0, COMMIT_CODE 0, ERROR 0, TIMEOUT 0, STATE_OUT 00, idle counter 0.
- Inputs are assumed synchronous to CLK and already debounced to single-cycle pulses upstream.

## Test plan
- **Basic entry and commit:** digits 1,2,3,4 on consecutive cycles, then COMMIT_EN.
  - DIGIT_COUNT steps 1..4.
  - DIGITS_OUT=0x4321 and COMPLETE=1 after the 4th digit.
  - COMMIT_VALID pulses once with COMMIT_CODE=0x4321; count returns to 0.
- **Overflow and invalid digit:**
  - Fill to 4 digits, send digit 5: ERROR pulses, DIGITS_OUT unchanged.
  - From IDLE, send digit 0xA: ERROR pulses, count stays 0.
- **Backspace:**
  - Enter 7,8,9, then BACKSPACE: DIGITS_OUT=0x087, count 2.
  - BACKSPACE three more times: the third one pulses ERROR in IDLE.
- **Simultaneous requests:**
  - Count 3, with DIGIT_EN(5), BACKSPACE_EN and CLEAR_EN in the same cycle: buffer cleared, count 0, no ERROR.
  - Count 4, with COMMIT_EN and DIGIT_EN: commit occurs and the digit is dropped.
- **Timeout:** TIMEOUT_CYCLES=10, enter digit 3, then hold inputs idle.
  - TIMEOUT pulses exactly 10 cycles after the accepted digit; count 0.
  - Repeat with a digit at cycle 9: the timer restarts and there is no TIMEOUT at cycle 10.
- **Reset and parametrisation:**
  - RESET mid-entry at count 2: all outputs return to reset values the next cycle.
  - Rerun the basic-entry scenario with NUM_DIGITS=6 and MAX_DIGIT=15: COMMIT_CODE=0xFEDCBA for entries A..F.
